dmem_io_bus: RTL
================

# dmem_io_bus

Parametrised data-memory-plus-IO device for the PMIPS pipelined processor, successor to the fixed two-switch / one-display data memory. Sits on the processor's data-memory port: word RAM below `IO_BASE`, memory-mapped IO registers at and above it. Adds generic width and depth, N switch inputs with synchronisation and optional debounce, sticky change flags and a readable cycle counter.

## Interface
- `WIDTH`, 16: data word width.
- `ADDR_W`, 16: byte-address width.
- `DEPTH`, 128: RAM depth in words; power of two.
- `NUM_SW`, 2: switch inputs; 1..`WIDTH`.
- `IO_BASE`, 16'hFFF0: first IO byte address; `IO_BASE` ≥ 2·`DEPTH`.
- `DEBOUNCE_CYC`, 4: stable cycles required to accept a switch change; ≥ 2.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all IO state immediately.
- `addr`  in  `ADDR_W`  byte address; bit 0 ignored.
- `wdata`  in  `WIDTH`  write data.
- `write`  in  1  write enable.
- `read`  in  1  read enable.
- `rdata`  out  `WIDTH`  read data.
- `io_sw`  in  `NUM_SW`  raw asynchronous switch inputs.
- `io_display`  out  7  seven-segment pattern register.

## Operation
- Word index is `addr[ADDR_W-1:1]`.
- RAM region (`addr` < `IO_BASE`): index taken modulo `DEPTH`. Writes occur at the edge when `write`=1. Reset does not clear RAM contents.
- IO map (byte offsets from `IO_BASE`):
  - +0 DISPLAY (R/W): low 7 bits drive `io_display`; reads zero-extended.
  - +2 SWITCH (R): debounced switch vector in bits [`NUM_SW`-1:0].
  - +4 CHANGE (R, clear-on-read): sticky per-switch flag, set when the debounced bit changes in either direction.
  - +6 CYCLES (R): free-running `WIDTH`-bit counter; increments every cycle; wraps from all-ones to 0.
  - +8 and above: read 0; writes ignored. Writes to +2/+4/+6 ignored.
- `rdata` is combinational from `addr` when `read`=1; 0 when `read`=0.
- Read and write in the same cycle to the same RAM word: `rdata` shows old data; new data is visible the following cycle.
- CHANGE clears at the edge where `read`=1 and `addr`=`IO_BASE`+4. If a flag sets at that same edge, set wins: the bit reads 1 afterwards.
- Switch path: 2-flop synchroniser per bit (`sync1`, `sync2`), then per-bit debounce into the SWITCH register.
- Reset values: `io_display`=0, `rdata`=0 (since `read` is gated), SWITCH=0, CHANGE=0, CYCLES=0, synchronisers=0, debounce counters=0.

## Timing
- RAM and IO reads: 0-cycle latency (combinational).
- Writes: visible after the capturing edge.
- Raw `io_sw` change sampled at edge k: `sync2` valid after edge k+1.
- With debounce: a per-bit counter increments each cycle while `sync2`≠SWITCH and returns to 0 when they are equal. SWITCH loads `sync2` at the edge where counter=`DEBOUNCE_CYC`-1 and they still differ; the counter then returns to 0. SWITCH is updated after edge k+1+`DEBOUNCE_CYC` (k+5 at default).
- Pulses shorter than `DEBOUNCE_CYC` cycles at `sync2` never reach SWITCH.
- CHANGE bit sets at the same edge SWITCH changes.
- `reset` asserted mid-operation clears all IO state within the same cycle, without waiting for an edge. After deassertion, CYCLES counts from 0 at the first edge.

## Configuration
- `DMEM_IO_DEBOUNCE_EN` defined: debounce counters are present, as described above.
- Undefined: no counters. SWITCH loads `sync2` every edge, so a change is visible after edge k+2. Every `sync2` change, including 1-cycle glitches, updates SWITCH and sets CHANGE. `DEBOUNCE_CYC` is unused.

## Test plan
- Reset, then release: `io_display`=0; read `IO_BASE`+6 at first check returns 0; after 10 edges it returns 10; preset near all-ones, it wraps 16'hFFFF→0.
- Write 16'h1234 to addr 4, then 16'hBEEF to addr 4+2·`DEPTH` -> read addr 4 returns 16'hBEEF (alias). Same-cycle read/write of addr 6 returns the old value.
- Write 16'h00FF to `IO_BASE` -> `io_display`=7'h7F; read returns 16'h007F. Write to `IO_BASE`+2 -> SWITCH unchanged.
- With `DMEM_IO_DEBOUNCE_EN`: `io_sw`=2'b01 held from edge k -> SWITCH reads 1 after edge k+5, not after k+4; CHANGE reads 2'b01; a second read returns 0. A 3-cycle pulse on `io_sw[1]` -> SWITCH and CHANGE stay 0. Without the macro, a 1-cycle pulse sets CHANGE[1].
- Change debounces at the same edge as a CHANGE read -> flag still reads 1 on the next read.
- Assert `reset` between edges mid-debounce with CHANGE=1 -> CHANGE, SWITCH and `io_display` go to 0 without a clock edge; RAM data is retained.

Source files
------------

// File: rtl/dmem_io_bus.sv
// Data memory with memory-mapped IO for the PMIPS pipeline: word RAM below IO_BASE, then display,
// switch, change-flag and cycle-counter registers. Define DMEM_IO_DEBOUNCE_EN to add switch debounce.
module dmem_io_bus #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned NUM_SW       = 2,
  parameter int unsigned IO_BASE      = 'hFFF0,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              write,
  input  logic              read,
  output logic [WIDTH-1:0]  rdata,
  input  logic [NUM_SW-1:0] io_sw,
  output logic [6:0]        io_display
);

  localparam int unsigned       RAM_AW    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-2:0] W_DISP    = (ADDR_W-1)'(0);
  localparam logic [ADDR_W-2:0] W_SW      = (ADDR_W-1)'(1);
  localparam logic [ADDR_W-2:0] W_CHG     = (ADDR_W-1)'(2);
  localparam logic [ADDR_W-2:0] W_CYC     = (ADDR_W-1)'(3);

  // Address decode; bit 0 is a byte offset within the word and never selects anything.
  logic              is_io;
  logic [ADDR_W-2:0] io_word;
  logic [RAM_AW-1:0] ram_idx;
  logic              chg_clr;

  assign is_io   = (addr >= IO_BASE_A);
  assign io_word = addr[ADDR_W-1:1] - IO_BASE_A[ADDR_W-1:1];
  assign ram_idx = addr[RAM_AW:1];
  assign chg_clr = read && is_io && (io_word == W_CHG);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [6:0]        disp_q, disp_d;
  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [NUM_SW-1:0] sw_q, sw_d;
  logic [NUM_SW-1:0] chg_q, chg_d;
  logic [WIDTH-1:0]  cyc_q, cyc_d;

  // RAM has no reset so its contents survive an IO reset.
  always_ff @(posedge clock) begin
    if (write && !is_io) begin
      mem_q[ram_idx] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (read) begin
      if (!is_io) begin
        rdata = mem_q[ram_idx];
      end else begin
        case (io_word)
          W_DISP:  rdata = WIDTH'(disp_q);
          W_SW:    rdata[NUM_SW-1:0] = sw_q;
          W_CHG:   rdata[NUM_SW-1:0] = chg_q;
          W_CYC:   rdata = cyc_q;
          default: rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    disp_d = disp_q;
    if (write && is_io && (io_word == W_DISP)) begin
      disp_d = wdata[6:0];
    end
  end

  assign cyc_d = cyc_q + WIDTH'(1);

`ifdef DMEM_IO_DEBOUNCE_EN
  localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt_q [NUM_SW];
  logic [CNT_W-1:0] cnt_d [NUM_SW];

  // A bit is accepted only after sync2 has disagreed with SWITCH for DEBOUNCE_CYC edges in a row.
  always_comb begin
    sw_d = sw_q;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  assign sw_d = sync2_q;
`endif

  // A flag raised at the same edge as a clearing read survives the clear.
  assign chg_d = (chg_clr ? '0 : chg_q) | (sw_d ^ sw_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
      chg_q   <= '0;
      cyc_q   <= '0;
    end else begin
      disp_q  <= disp_d;
      sync1_q <= io_sw;
      sync2_q <= sync1_q;
      sw_q    <= sw_d;
      chg_q   <= chg_d;
      cyc_q   <= cyc_d;
    end
  end

  assign io_display = disp_q;

endmodule
